// File: rtl/fp32_pkg.sv
// Shared single-precision constants and the multiplier FSM state encoding.
package fp32_pkg;

  localparam int          EXP_MAX   = 255;
  localparam int          EXP_BIAS  = 127;
  localparam logic [23:0] QNAN_FRAC = 24'h400000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } fmul_state_t;

endpackage

// File: rtl/fmul_seq_if.sv
// Operand/result handshake bundle for the sequential FP multiplier.
// The master drives operands and out_ready; the slave (fmul_seq) returns the result.
interface fmul_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic        A_sign;
  logic [7:0]  A_exp;
  logic [22:0] A_frac;
  logic        B_sign;
  logic [7:0]  B_exp;
  logic [22:0] B_frac;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [23:0] frac;
  logic        error;
  logic        overflow;

  modport master (
    output in_valid, A_sign, A_exp, A_frac, B_sign, B_exp, B_frac, out_ready,
    input  in_ready, out_valid, sign, exp, frac, error, overflow
  );

  modport slave (
    input  in_valid, A_sign, A_exp, A_frac, B_sign, B_exp, B_frac, out_ready,
    output in_ready, out_valid, sign, exp, frac, error, overflow
  );

endinterface

// File: rtl/fp32_classify.sv
// Combinational operand classifier for single-precision values (shared with the divider).
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [7:0]  exp_i,
  input  logic [22:0] frac_i,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_denorm
);

  localparam logic [7:0] EXP_ONES = 8'(EXP_MAX);

  assign is_zero   = (exp_i == 8'd0)     && (frac_i == 23'd0);
  assign is_denorm = (exp_i == 8'd0)     && (frac_i != 23'd0);
  assign is_inf    = (exp_i == EXP_ONES) && (frac_i == 23'd0);
  assign is_nan    = (exp_i == EXP_ONES) && (frac_i != 23'd0);

endmodule

// File: rtl/fmul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier with an iterative shift-add core.
// Optional build macro FMUL_ROUND_EN: round-to-nearest-even in NORM (default truncates).
module fmul_seq
  import fp32_pkg::*;
#(
  parameter int RADIX_BITS = 1,
  parameter int EXP_BIAS   = fp32_pkg::EXP_BIAS
) (
  input logic       clk,
  input logic       rst,
  fmul_seq_if.slave bus
);

  localparam int ITER = 24 / RADIX_BITS;

  fmul_state_t        state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [23:0]        mc_q, mc_d;
  logic [23:0]        mp_q, mp_d;
  logic [47:0]        p_q, p_d;
  logic signed [9:0]  e_q, e_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [23:0]        frac_q, frac_d;
  logic               error_q, error_d;
  logic               overflow_q, overflow_d;

  logic a_zero, a_inf, a_nan, a_denorm;
  logic b_zero, b_inf, b_nan, b_denorm;
  logic a_flush, b_flush;

  logic [47:0]        pp;
  logic [5:0]         shamt;
  logic [23:0]        mant_raw, norm_mant;
  logic signed [9:0]  e_raw, norm_e;
`ifdef FMUL_ROUND_EN
  logic               guard, sticky;
  logic [24:0]        mant_rnd;
`endif

  fp32_classify u_cls_a (
    .exp_i    (bus.A_exp),
    .frac_i   (bus.A_frac),
    .is_zero  (a_zero),
    .is_inf   (a_inf),
    .is_nan   (a_nan),
    .is_denorm(a_denorm)
  );

  fp32_classify u_cls_b (
    .exp_i    (bus.B_exp),
    .frac_i   (bus.B_frac),
    .is_zero  (b_zero),
    .is_inf   (b_inf),
    .is_nan   (b_nan),
    .is_denorm(b_denorm)
  );

  // Denormals are flushed, so they behave exactly like zero.
  assign a_flush = a_zero | a_denorm;
  assign b_flush = b_zero | b_denorm;

  // Partial product for the RADIX_BITS multiplier bits retired this cycle, placed at its weight.
  assign pp    = 48'(mc_q) * 48'(mp_q[RADIX_BITS-1:0]);
  assign shamt = 6'(int'(cnt_q) * RADIX_BITS);

  // Normalise the 48-bit product and optionally round it.
  always_comb begin
    if (p_q[47]) begin
      mant_raw = p_q[47:24];
      e_raw    = e_q + 10'sd1;
    end else begin
      mant_raw = p_q[46:23];
      e_raw    = e_q;
    end
`ifdef FMUL_ROUND_EN
    guard    = p_q[47] ? p_q[23] : p_q[22];
    sticky   = p_q[47] ? (|p_q[22:0]) : (|p_q[21:0]);
    mant_rnd = {1'b0, mant_raw} + {24'd0, guard & (sticky | mant_raw[0])};
    if (mant_rnd[24]) begin
      norm_mant = 24'h800000;
      norm_e    = e_raw + 10'sd1;
    end else begin
      norm_mant = mant_rnd[23:0];
      norm_e    = e_raw;
    end
`else
    norm_mant = mant_raw;
    norm_e    = e_raw;
`endif
  end

  // Next-state and datapath updates for IDLE/CALC/NORM/DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mc_d       = mc_q;
    mp_d       = mp_q;
    p_d        = p_q;
    e_d        = e_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    frac_d     = frac_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d     = bus.A_sign ^ bus.B_sign;
          error_d    = 1'b0;
          overflow_d = 1'b0;
          if (a_nan || b_nan || (a_flush && b_inf) || (b_flush && a_inf)) begin
            exp_d   = 8'hFF;
            frac_d  = QNAN_FRAC;
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (a_inf || b_inf) begin
            exp_d      = 8'hFF;
            frac_d     = 24'd0;
            overflow_d = 1'b1;
            state_d    = S_DONE;
          end else if (a_flush || b_flush) begin
            exp_d   = 8'd0;
            frac_d  = 24'd0;
            state_d = S_DONE;
          end else begin
            mc_d    = {1'b1, bus.A_frac};
            mp_d    = {1'b1, bus.B_frac};
            p_d     = 48'd0;
            cnt_d   = 5'd0;
            e_d     = $signed({2'b00, bus.A_exp}) + $signed({2'b00, bus.B_exp})
                      - $signed(10'(EXP_BIAS));
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d   = p_q + (pp << shamt);
        mp_d  = mp_q >> RADIX_BITS;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (norm_e >= 10'sd255) begin
          exp_d      = 8'hFF;
          frac_d     = 24'd0;
          overflow_d = 1'b1;
        end else if (norm_e <= 10'sd0) begin
          exp_d  = 8'd0;
          frac_d = 24'd0;
        end else begin
          exp_d  = norm_e[7:0];
          frac_d = norm_mant;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      mc_q       <= 24'd0;
      mp_q       <= 24'd0;
      p_q        <= 48'd0;
      e_q        <= 10'sd0;
      sign_q     <= 1'b0;
      exp_q      <= 8'd0;
      frac_q     <= 24'd0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mc_q       <= mc_d;
      mp_q       <= mp_d;
      p_q        <= p_d;
      e_q        <= e_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      frac_q     <= frac_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sign      = sign_q;
  assign bus.exp       = exp_q;
  assign bus.frac      = frac_q;
  assign bus.error     = error_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fmul_seq.sv
// Self-checking bench for fmul_seq: directed vectors, randomized operands against a
// behavioural model, backpressure, and reset during an operation.
module tb_fmul_seq;

  localparam int RADIX   = 1;
  localparam int LAT_NRM = 24 / RADIX + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fmul_seq_if bus_if ();

  fmul_seq #(.RADIX_BITS(RADIX), .EXP_BIAS(127)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference: result as {sign, exp, frac, error, overflow} from plain integer arithmetic.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ae, be, e, sh;
    longint af, bf, p, f;
    bit     az, bz, ai, bi, an, bn;
`ifdef FMUL_ROUND_EN
    bit     g, st;
`endif
    s  = a[31] ^ b[31];
    ae = int'(a[30:23]);
    be = int'(b[30:23]);
    af = longint'(a[22:0]);
    bf = longint'(b[22:0]);
    az = (ae == 0);
    bz = (be == 0);
    ai = (ae == 255) && (af == 0);
    bi = (be == 255) && (bf == 0);
    an = (ae == 255) && (af != 0);
    bn = (be == 255) && (bf != 0);
    if (an || bn || (az && bi) || (bz && ai)) return {s, 8'hFF, 24'h400000, 2'b10};
    if (ai || bi) return {s, 8'hFF, 24'h000000, 2'b01};
    if (az || bz) return {s, 8'h00, 24'h000000, 2'b00};
    p = (af + 64'd8388608) * (bf + 64'd8388608);
    e = ae + be - 127;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    f = p >> sh;
`ifdef FMUL_ROUND_EN
    g  = ((p >> (sh - 1)) & 64'd1) != 0;
    st = (p % (64'd1 << (sh - 1))) != 0;
    if (g && (st || (f % 2 == 1))) f = f + 1;
    if (f == (64'd1 << 24)) begin
      f = 64'd1 << 23;
      e = e + 1;
    end
`endif
    if (e >= 255) return {s, 8'hFF, 24'h000000, 2'b01};
    if (e <= 0) return {s, 8'h00, 24'h000000, 2'b00};
    return {s, 8'(e), 24'(f), 2'b00};
  endfunction

  function automatic logic [34:0] observed();
    return {bus_if.sign, bus_if.exp, bus_if.frac, bus_if.error, bus_if.overflow};
  endfunction

  // Present one operand pair, wait (bounded) for the result; lat counts edges from accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [34:0] got, output int lat);
    int waited;
    waited = 0;
    while (bus_if.in_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    bus_if.A_sign   = a[31];
    bus_if.A_exp    = a[30:23];
    bus_if.A_frac   = a[22:0];
    bus_if.B_sign   = b[31];
    bus_if.B_exp    = b[30:23];
    bus_if.B_frac   = b[22:0];
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    got = observed();
  endtask

  task automatic release_out();
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if ({bus_if.out_valid, bus_if.in_ready, observed()} !== {2'b01, 35'd0}) begin
      n_err++;
      $display("FAIL reset: got valid/ready/result=%h required %h",
               {bus_if.out_valid, bus_if.in_ready, observed()}, {2'b01, 35'd0});
    end
    $display("reset: out_valid=%b in_ready=%b", bus_if.out_valid, bus_if.in_ready);
  endtask

  task automatic test_directed();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [34:0] te [10];
    int          tl [10];
    logic [34:0] got;
    int          lat;
    ta[0] = {1'b0, 8'd127, 23'h400000}; tb[0] = {1'b0, 8'd128, 23'h0};
    te[0] = {1'b0, 8'd128, 24'hC00000, 2'b00}; tl[0] = LAT_NRM;
    ta[1] = {1'b0, 8'd127, 23'h400000}; tb[1] = {1'b0, 8'd127, 23'h400000};
    te[1] = {1'b0, 8'd128, 24'h900000, 2'b00}; tl[1] = LAT_NRM;
    ta[2] = {1'b0, 8'd0, 23'h0};        tb[2] = {1'b1, 8'd255, 23'h0};
    te[2] = {1'b1, 8'hFF, 24'h400000, 2'b10};  tl[2] = 1;
    ta[3] = {1'b0, 8'd254, 23'h0};      tb[3] = {1'b0, 8'd128, 23'h0};
    te[3] = {1'b0, 8'hFF, 24'h000000, 2'b01};  tl[3] = LAT_NRM;
    ta[4] = {1'b0, 8'd127, 23'h000800}; tb[4] = {1'b0, 8'd127, 23'h000801};
`ifdef FMUL_ROUND_EN
    te[4] = {1'b0, 8'd127, 24'h801002, 2'b00}; tl[4] = LAT_NRM;
`else
    te[4] = {1'b0, 8'd127, 24'h801001, 2'b00}; tl[4] = LAT_NRM;
`endif
    ta[5] = {1'b0, 8'd1, 23'h0};        tb[5] = {1'b0, 8'd1, 23'h0};
    te[5] = {1'b0, 8'd0, 24'h000000, 2'b00};   tl[5] = LAT_NRM;
    ta[6] = {1'b1, 8'd255, 23'h0};      tb[6] = {1'b0, 8'd100, 23'h5};
    te[6] = {1'b1, 8'hFF, 24'h000000, 2'b01};  tl[6] = 1;
    ta[7] = {1'b0, 8'd255, 23'h1};      tb[7] = {1'b0, 8'd127, 23'h0};
    te[7] = {1'b0, 8'hFF, 24'h400000, 2'b10};  tl[7] = 1;
    ta[8] = {1'b0, 8'd0, 23'h7B};       tb[8] = {1'b1, 8'd130, 23'h0};
    te[8] = {1'b1, 8'd0, 24'h000000, 2'b00};   tl[8] = 1;
    ta[9] = {1'b1, 8'd127, 23'h0};      tb[9] = {1'b1, 8'd127, 23'h0};
    te[9] = {1'b0, 8'd127, 24'h800000, 2'b00}; tl[9] = LAT_NRM;
    for (int i = 0; i < 10; i++) begin
      do_op(ta[i], tb[i], got, lat);
      n_vec++;
      if (got !== te[i] || lat != tl[i]) begin
        n_err++;
        $display("FAIL directed[%0d]: got result=%h lat=%0d required result=%h lat=%0d",
                 i, got, lat, te[i], tl[i]);
      end
      $display("directed[%0d]: a=%h b=%h result=%h lat=%0d", i, ta[i], tb[i], got, lat);
      release_out();
    end
  endtask

  function automatic logic [7:0] rand_exp();
    int r;
    r = int'($urandom_range(0, 11));
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd255;
    if (r == 2) return 8'($urandom_range(1, 254));
    return 8'($urandom_range(64, 190));
  endfunction

  task automatic test_random();
    logic [31:0] a, b;
    logic [34:0] got, expv;
    int          lat, lat_exp;
    for (int i = 0; i < 60; i++) begin
      a = {1'($urandom), rand_exp(), 23'($urandom)};
      b = {1'($urandom), rand_exp(), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) a[22:0] = 23'd0;
      if ($urandom_range(0, 7) == 0) b[22:0] = 23'd0;
      expv    = ref_mul(a, b);
      lat_exp = (a[30:23] == 8'd0 || a[30:23] == 8'd255 ||
                 b[30:23] == 8'd0 || b[30:23] == 8'd255) ? 1 : LAT_NRM;
      do_op(a, b, got, lat);
      n_vec++;
      if (got !== expv || lat != lat_exp) begin
        n_err++;
        $display("FAIL random[%0d]: a=%h b=%h got result=%h lat=%0d required result=%h lat=%0d",
                 i, a, b, got, lat, expv, lat_exp);
      end
      $display("random[%0d]: a=%h b=%h result=%h lat=%0d", i, a, b, got, lat);
      release_out();
    end
  endtask

  task automatic test_backpressure_and_abort();
    logic [34:0] got, held;
    int          lat, seen;
    do_op({1'b0, 8'd127, 23'h400000}, {1'b0, 8'd128, 23'h0}, held, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({bus_if.out_valid, bus_if.in_ready, observed()} !== {2'b10, held}) begin
        n_err++;
        $display("FAIL hold[%0d]: got valid/ready/result=%h required %h",
                 i, {bus_if.out_valid, bus_if.in_ready, observed()}, {2'b10, held});
      end
    end
    $display("backpressure: held result=%h for 10 cycles", held);
    release_out();
    n_vec++;
    if ({bus_if.out_valid, bus_if.in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL release: got valid/ready=%b required 01", {bus_if.out_valid, bus_if.in_ready});
    end
    // Second operation, aborted by reset mid-CALC.
    bus_if.A_sign = 1'b0; bus_if.A_exp = 8'd130; bus_if.A_frac = 23'h123456;
    bus_if.B_sign = 1'b1; bus_if.B_exp = 8'd120; bus_if.B_frac = 23'h654321;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({bus_if.out_valid, bus_if.in_ready, observed()} !== {2'b01, 35'd0}) begin
      n_err++;
      $display("FAIL abort: got valid/ready/result=%h required %h",
               {bus_if.out_valid, bus_if.in_ready, observed()}, {2'b01, 35'd0});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_silent: got %0d out_valid cycles required 0", seen);
    end
    $display("abort: reset mid-CALC, out_valid cycles afterwards=%0d", seen);
    // Recovery with a fresh operation.
    do_op({1'b1, 8'd127, 23'h400000}, {1'b0, 8'd128, 23'h0}, got, lat);
    n_vec++;
    if (got !== {1'b1, 8'd128, 24'hC00000, 2'b00} || lat != LAT_NRM) begin
      n_err++;
      $display("FAIL recover: got result=%h lat=%0d required %h lat=%0d",
               got, lat, {1'b1, 8'd128, 24'hC00000, 2'b00}, LAT_NRM);
    end
    $display("recover: result=%h lat=%0d", got, lat);
    release_out();
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.A_sign = 1'b0; bus_if.A_exp = 8'd0; bus_if.A_frac = 23'd0;
    bus_if.B_sign = 1'b0; bus_if.B_exp = 8'd0; bus_if.B_frac = 23'd0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure_and_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
